imem_fetch_arbiter: RTL and testbench
=====================================

# imem_fetch_arbiter

Sequencer and arbiter for the byte-addressed instruction memory read port. It shares the single combinational `IMem` read path between the CPU fetch stage and a debug/loader reader. Each access is registered, alignment- and range-checked, and returned through a valid/ready response handshake. It sits between the fetch stage, the debug interface and `IMem`.

## Interface
- `MEM_BYTES`, 400: size of the instruction memory in bytes.
- `STARVE_MAX`, 4: consecutive fetch wins allowed while debug waits; legal range 1..15.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `f_req` in 1: fetch request; held high until `f_gnt`.
- `f_adrs` in 32: fetch byte address; sampled when `f_gnt` is high.
- `f_gnt` out 1: fetch request accepted (combinational, this cycle).
- `f_vld` out 1: fetch response valid.
- `f_data` out 32: fetch instruction word.
- `f_err` out 1: fetch response is an error.
- `f_rdy` in 1: fetch consumer accepts the response.
- `d_req`, `d_adrs`, `d_gnt`, `d_vld`, `d_data`, `d_err`, `d_rdy`: debug port; widths and rules identical to the fetch port.
- `mem_adrs` out 32: address driven to `IMem` `RAdrs`.
- `mem_data` in 32: `IMem` `ITM` word (combinational from `mem_adrs`).

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ISSUE: drive memory, capture word.
  - RESP: hold response.
- In IDLE, if any request is present, exactly one grant is high combinationally. At the clock edge:
  - the winner's address and ID are latched;
  - the range check is evaluated.
- Arbitration:
  - Fetch wins by default.
  - Debug wins when `d_req` and (`!f_req` or `starve_cnt == STARVE_MAX`).
- `starve_cnt` (4 bits):
  - +1 when fetch wins while `d_req` is high;
  - cleared when debug wins;
  - unchanged otherwise.
- Error check, done at grant using unsigned 32-bit compare with no overflow: error if `adrs[1:0] != 0` or `adrs > MEM_BYTES-4`.
- IDLE transitions:
  - valid address → ISSUE;
  - error → RESP with `err=1`, `data=0`, and no memory access.
- ISSUE: `mem_adrs` = latched address. `mem_data` is registered into the response register at the edge, then → RESP.
- RESP: the owner's `x_vld=1`, `x_data` and `x_err` are stable. Transitions:
  - `x_rdy` high → IDLE, clear `vld`;
  - `x_rdy` low → stay in RESP.
- The non-owner's `vld` is always 0.
- No new grant is issued outside IDLE, so requests arriving in ISSUE/RESP wait.
- `mem_adrs` holds the last latched address outside ISSUE, so it is never X.

## Timing
- Reset values:
  - state IDLE;
  - `f_vld`/`d_vld`/`f_err`/`d_err` = 0;
  - `f_data`/`d_data` = 0;
  - `mem_adrs` = 0;
  - `starve_cnt` = 0.
- `f_gnt`/`d_gnt` are 0 while `rst_n` is low.
- Latency for a valid address: grant in cycle T, `vld` high in cycle T+2.
- Latency for an error: `vld` high in T+1.
- Throughput: one transaction per 3 cycles with `rdy` tied high; 2 cycles for errors.
- `rdy` sampled high in cycle N → `vld` low in N+1. The earliest next grant is in cycle N+1.
- Simultaneous `f_req`/`d_req` below the starvation limit: fetch wins. At the limit: debug wins and the counter clears.
- Reset asserted in any state: the in-flight transaction is dropped, and all outputs take reset values at that edge.
- `x_rdy` high while `x_vld` is low: ignored.

## Configuration
- `IMEM_ARB_STATS_EN` defined adds three outputs:
  - `stat_fetch` (16): valid fetch responses accepted;
  - `stat_dbg` (16): valid debug responses accepted;
  - `stat_err` (16): error responses accepted, either port.
- Counters increment on the RESP→IDLE handshake, saturate at 16'hFFFF, and reset to 0.
- `IMEM_ARB_STATS_EN` undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Memory preloaded with `IMem[0..3]=8'h20,8'h08,8'h00,8'h05`; fetch `f_adrs=0`, `f_rdy=1` → `f_gnt` at T, `f_vld` at T+2 with `f_data=32'h20080005`, `f_err=0`.
- Misaligned and out-of-range fetches:
  - `f_adrs=32'h2` → `f_vld` at T+1, `f_err=1`, `f_data=0`, `mem_adrs` unchanged.
  - `f_adrs=397` → same error response.
  - `f_adrs=396` → valid response.
- `f_req` and `d_req` held high continuously with `STARVE_MAX=4`, `rdy=1` → grant order F,F,F,F,D,F,F,F,F,D.
- Backpressure: `f_rdy=0` for 5 cycles after `f_vld` → `f_vld`, `f_data` and state held; no `d_gnt` despite `d_req`; `d_gnt` appears the cycle after `f_rdy` rises.
- `rst_n` low during ISSUE, then during RESP → next cycle all outputs 0, state IDLE; a new request after release completes normally.
- `IMEM_ARB_STATS_EN` defined: 3 valid fetches, 2 debug reads, 1 error → `stat_fetch=3`, `stat_dbg=2`, `stat_err=1`.

Source files
------------

// File: rtl/imem_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// imem_fetch_arbiter: shares the IMem read port between fetch and debug readers
// Optional IMEM_ARB_STATS_EN adds accepted-response counters. Rev 1.0
// ============================================================================
module imem_fetch_arbiter #(
  parameter int MEM_BYTES  = 400,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [31:0] f_adrs,
  output logic        f_gnt,
  output logic        f_vld,
  output logic [31:0] f_data,
  output logic        f_err,
  input  logic        f_rdy,
  input  logic        d_req,
  input  logic [31:0] d_adrs,
  output logic        d_gnt,
  output logic        d_vld,
  output logic [31:0] d_data,
  output logic        d_err,
  input  logic        d_rdy,
  output logic [31:0] mem_adrs,
  input  logic [31:0] mem_data
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_fetch,
  output logic [15:0] stat_dbg,
  output logic [15:0] stat_err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [31:0] LAST_WORD  = 32'(MEM_BYTES - 4);
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

  state_t      state, state_nxt;
  logic        owner;          // 1: debug owns the transaction
  logic [31:0] resp_data;
  logic        resp_err;
  logic [3:0]  starve_cnt;
  logic        d_win;
  logic        sel_err;
  logic        rdy_sel;
  logic [31:0] sel_adrs;

  always_comb begin
    state_nxt = state;
    f_gnt     = 1'b0;
    d_gnt     = 1'b0;
    d_win     = d_req && (!f_req || (starve_cnt == STARVE_LIM));
    sel_adrs  = d_win ? d_adrs : f_adrs;
    sel_err   = (sel_adrs[1:0] != 2'b00) || (sel_adrs > LAST_WORD);
    rdy_sel   = owner ? d_rdy : f_rdy;
    case (state)
      IDLE: begin
        if (rst_n && (f_req || d_req)) begin
          f_gnt     = !d_win;
          d_gnt     = d_win;
          state_nxt = sel_err ? RESP : ISSUE;
        end
      end
      ISSUE:   state_nxt = RESP;
      RESP:    if (rdy_sel) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      mem_adrs   <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (f_gnt || d_gnt) begin
            owner <= d_win;
            if (d_win)      starve_cnt <= '0;
            else if (d_req) starve_cnt <= starve_cnt + 4'd1;
            // Errored accesses never reach IMem, so mem_adrs keeps its last value.
            if (sel_err) begin
              resp_err  <= 1'b1;
              resp_data <= '0;
            end else begin
              mem_adrs  <= sel_adrs;
            end
          end
        end
        ISSUE: begin
          resp_data <= mem_data;
          resp_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign f_vld  = (state == RESP) && !owner;
  assign d_vld  = (state == RESP) && owner;
  assign f_data = f_vld ? resp_data : '0;
  assign d_data = d_vld ? resp_data : '0;
  assign f_err  = f_vld && resp_err;
  assign d_err  = d_vld && resp_err;

`ifdef IMEM_ARB_STATS_EN
  logic hs;
  assign hs = (state == RESP) && rdy_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_fetch <= '0;
      stat_dbg   <= '0;
      stat_err   <= '0;
    end else if (hs) begin
      if (resp_err) begin
        if (stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
      end else if (owner) begin
        if (stat_dbg != 16'hFFFF) stat_dbg <= stat_dbg + 16'd1;
      end else begin
        if (stat_fetch != 16'hFFFF) stat_fetch <= stat_fetch + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_arbiter.sv
`default_nettype none
// Directed testbench for imem_fetch_arbiter with a byte-array IMem model.
module tb_imem_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, f_gnt, f_vld, f_err, f_rdy;
  logic        d_req, d_gnt, d_vld, d_err, d_rdy;
  logic [31:0] f_adrs, f_data, d_adrs, d_data, mem_adrs, mem_data;
`ifdef IMEM_ARB_STATS_EN
  logic [15:0] stat_fetch, stat_dbg, stat_err;
`endif

  logic [7:0] mem [0:399];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_fetch_arbiter #(.MEM_BYTES(400), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_adrs(f_adrs), .f_gnt(f_gnt), .f_vld(f_vld),
    .f_data(f_data), .f_err(f_err), .f_rdy(f_rdy),
    .d_req(d_req), .d_adrs(d_adrs), .d_gnt(d_gnt), .d_vld(d_vld),
    .d_data(d_data), .d_err(d_err), .d_rdy(d_rdy),
    .mem_adrs(mem_adrs), .mem_data(mem_data)
`ifdef IMEM_ARB_STATS_EN
    , .stat_fetch(stat_fetch), .stat_dbg(stat_dbg), .stat_err(stat_err)
`endif
  );

  // Big-endian word read, zero beyond the last full word.
  always_comb begin
    mem_data = '0;
    if (mem_adrs <= 32'd396)
      for (int k = 0; k < 4; k++)
        mem_data[31-8*k -: 8] = mem[int'(mem_adrs[8:0]) + k];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic f_txn(input logic [31:0] a, input logic err, input logic [31:0] d,
                       input logic [31:0] exp_mem);
    f_req = 1'b1; f_adrs = a; f_rdy = 1'b1;
    #1;
    chk("f_gnt", {31'b0, f_gnt}, 32'd1);
    chk("f_d_gnt_low", {31'b0, d_gnt}, 32'd0);
    tick();
    f_req = 1'b0;
    if (!err) begin
      chk("f_vld_issue", {31'b0, f_vld}, 32'd0);
      tick();
    end
    chk("f_vld", {31'b0, f_vld}, 32'd1);
    chk("f_err", {31'b0, f_err}, {31'b0, err});
    chk("f_data", f_data, d);
    chk("f_mem_adrs", mem_adrs, exp_mem);
    chk("f_d_vld_low", {31'b0, d_vld}, 32'd0);
    tick();
    chk("f_vld_clear", {31'b0, f_vld}, 32'd0);
  endtask

  task automatic d_txn(input logic [31:0] a, input logic err, input logic [31:0] d);
    d_req = 1'b1; d_adrs = a; d_rdy = 1'b1;
    #1;
    chk("d_gnt", {31'b0, d_gnt}, 32'd1);
    tick();
    d_req = 1'b0;
    if (!err) tick();
    chk("d_vld", {31'b0, d_vld}, 32'd1);
    chk("d_err", {31'b0, d_err}, {31'b0, err});
    chk("d_data", d_data, d);
    chk("d_f_vld_low", {31'b0, f_vld}, 32'd0);
    tick();
    chk("d_vld_clear", {31'b0, d_vld}, 32'd0);
  endtask

  initial begin
    logic [9:0] arb_exp;
    int n;
    for (int i = 0; i < 400; i++) mem[i] = 8'(i);
    mem[0] = 8'h20; mem[1] = 8'h08; mem[2] = 8'h00; mem[3] = 8'h05;

    rst_n = 1'b0; f_req = 1'b1; d_req = 1'b0; f_adrs = '0; d_adrs = '0;
    f_rdy = 1'b1; d_rdy = 1'b1;
    tick(); tick();
    chk("rst_f_gnt", {31'b0, f_gnt}, 32'd0);
    chk("rst_f_vld", {31'b0, f_vld}, 32'd0);
    chk("rst_d_vld", {31'b0, d_vld}, 32'd0);
    chk("rst_f_data", f_data, 32'd0);
    chk("rst_f_err", {31'b0, f_err}, 32'd0);
    chk("rst_mem_adrs", mem_adrs, 32'd0);
    f_req = 1'b0; rst_n = 1'b1;
    tick();

    // Basic, boundary and error fetches
    f_txn(32'd0,   1'b0, 32'h20080005, 32'd0);
    f_txn(32'd396, 1'b0, 32'h8C8D8E8F, 32'd396);
    f_txn(32'h2,   1'b1, 32'h0,        32'd396);
    f_txn(32'd397, 1'b1, 32'h0,        32'd396);
    d_txn(32'd400, 1'b1, 32'h0);

    // Starvation: both requesting continuously
    arb_exp = 10'b10_0001_0000;
    f_req = 1'b1; f_adrs = 32'd4; d_req = 1'b1; d_adrs = 32'd8;
    f_rdy = 1'b1; d_rdy = 1'b1;
    #1;
    for (int g = 0; g < 10; g++) begin
      n = 0;
      while (!(f_gnt || d_gnt) && n < 8) begin
        tick();
        n++;
      end
      chk("arb_timeout", {31'b0, (n < 8)}, 32'd1);
      chk("arb_dbg_win", {31'b0, d_gnt}, {31'b0, arb_exp[g]});
      tick();
    end
    f_req = 1'b0; d_req = 1'b0;
    tick();
    chk("arb_d_vld", {31'b0, d_vld}, 32'd1);
    chk("arb_d_data", d_data, 32'h08090A0B);
    tick();

    // Backpressure on fetch with debug waiting
    f_req = 1'b1; f_adrs = 32'd4; f_rdy = 1'b0;
    #1;
    chk("bp_f_gnt", {31'b0, f_gnt}, 32'd1);
    tick();
    f_req = 1'b0; d_req = 1'b1; d_adrs = 32'd8;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_f_vld", {31'b0, f_vld}, 32'd1);
      chk("bp_f_data", f_data, 32'h04050607);
      chk("bp_no_d_gnt", {31'b0, d_gnt}, 32'd0);
      tick();
    end
    f_rdy = 1'b1;
    #1;
    chk("bp_no_d_gnt_rdy", {31'b0, d_gnt}, 32'd0);
    tick();
    chk("bp_f_vld_clear", {31'b0, f_vld}, 32'd0);
    chk("bp_d_gnt", {31'b0, d_gnt}, 32'd1);
    tick();
    d_req = 1'b0;
    tick();
    chk("bp_d_vld", {31'b0, d_vld}, 32'd1);
    chk("bp_d_data", d_data, 32'h08090A0B);
    tick();

    // Reset during ISSUE
    f_req = 1'b1; f_adrs = 32'd12;
    tick();
    f_req = 1'b0;
    chk("ri_mem_adrs", mem_adrs, 32'd12);
    rst_n = 1'b0;
    tick();
    chk("ri_mem_adrs_rst", mem_adrs, 32'd0);
    chk("ri_f_vld", {31'b0, f_vld}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ri_no_resp", {31'b0, f_vld}, 32'd0);

    // Reset during RESP
    f_req = 1'b1; f_adrs = 32'd16; f_rdy = 1'b0;
    tick();
    f_req = 1'b0;
    tick();
    chk("rr_f_vld", {31'b0, f_vld}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rr_f_vld_rst", {31'b0, f_vld}, 32'd0);
    chk("rr_f_data_rst", f_data, 32'd0);
    chk("rr_mem_adrs_rst", mem_adrs, 32'd0);
    rst_n = 1'b1; f_rdy = 1'b1;
    tick();
    f_txn(32'd0, 1'b0, 32'h20080005, 32'd0);

    // Mixed sequence after a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    f_txn(32'd4,   1'b0, 32'h04050607, 32'd4);
    f_txn(32'd8,   1'b0, 32'h08090A0B, 32'd8);
    f_txn(32'd12,  1'b0, 32'h0C0D0E0F, 32'd12);
    d_txn(32'd16,  1'b0, 32'h10111213);
    d_txn(32'd20,  1'b0, 32'h14151617);
    f_txn(32'd397, 1'b1, 32'h0,        32'd20);
`ifdef IMEM_ARB_STATS_EN
    chk("stat_fetch", {16'b0, stat_fetch}, 32'd3);
    chk("stat_dbg",   {16'b0, stat_dbg},   32'd2);
    chk("stat_err",   {16'b0, stat_err},   32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
